// File: rtl/cv_xif_pkg.sv
// Shared types for the CV-X-IF result arbiter: result payload, index width helper,
// and the decoupling-buffer occupancy encoding.
package cv_xif_pkg;

    typedef struct packed {
        logic [1:0]  hartid;
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  ecswe;
        logic [5:0]  ecsdata;
        logic        exc;
        logic [5:0]  exccode;
        logic        dbg;
        logic        err;
    } x_result_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

endpackage

// File: rtl/cv_xif_rr_arbiter.sv
// Combinational round-robin winner select: first valid requester at or above
// rr_ptr, wrapping back to 0.
module cv_xif_rr_arbiter #(
    parameter int NUM_COP = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_COP-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    logic found;

    always_comb begin
        winner    = '0;
        found     = 1'b0;
        any_valid = |valid;
        for (int k = 0; k < NUM_COP; k++) begin
            if (!found && valid[(int'(rr_ptr) + k) % NUM_COP]) begin
                winner = IDX_W'((int'(rr_ptr) + k) % NUM_COP);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cv_xif_result_arbiter.sv
// Shares the CPU result port among NUM_COP coprocessors through a 2-entry buffer,
// so coprocessor ready never depends on the CPU's ready.
module cv_xif_result_arbiter
    import cv_xif_pkg::*;
#(
    parameter int  NUM_COP  = 2,
    parameter type result_t = logic [31:0],
    parameter int  IDX_W    = idx_width(NUM_COP)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_COP-1:0] cop_result_valid_i,
    output logic [NUM_COP-1:0] cop_result_ready_o,
    input  result_t            cop_result_i [NUM_COP],
    output logic               cpu_result_valid_o,
    input  logic               cpu_result_ready_i,
    output result_t            cpu_result_o,
    output logic [IDX_W-1:0]   cpu_result_src_o
);

    occ_e             state;
    logic [IDX_W-1:0] rr_ptr, winner, rr_next;
    logic             any_valid, accept_en, push, pop;
    logic             wr_ptr, rd_ptr;
    result_t          mem_res [2];
    logic [IDX_W-1:0] mem_src [2];

    cv_xif_rr_arbiter #(.NUM_COP(NUM_COP), .IDX_W(IDX_W)) u_rr (
        .valid     (cop_result_valid_i),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // accept_en comes from registered occupancy only, keeping cpu ready out of cop ready.
    assign accept_en = (state != TWO);
    assign push      = accept_en && any_valid;
    assign pop       = cpu_result_valid_o && cpu_result_ready_i;
    assign rr_next   = (winner == IDX_W'(NUM_COP - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        cop_result_ready_o = '0;
        for (int i = 0; i < NUM_COP; i++)
            if (push && winner == IDX_W'(i)) cop_result_ready_o[i] = 1'b1;
    end

    assign cpu_result_valid_o = (state != EMPTY);
    assign cpu_result_o       = cpu_result_valid_o ? mem_res[rd_ptr] : result_t'('0);
    assign cpu_result_src_o   = cpu_result_valid_o ? mem_src[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_res[wr_ptr] <= cop_result_i[winner];
            mem_src[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                rr_ptr <= rr_next;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case (state)
                EMPTY: if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)      state <= TWO;
                    else if (pop && !push) state <= EMPTY;
                end
                TWO:     if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: doc/cv_xif_result_arbiter.md
# cv_xif_result_arbiter

Round-robin arbiter that shares the single CV-X-IF result port of the host CPU among `NUM_COP` coprocessors. It accepts each coprocessor's result handshake, tags the result with its source index, and forwards it to the CPU through a 2-entry decoupling buffer. Because of that buffer, no coprocessor `ready` depends combinationally on the CPU `result_ready`. The block sits between the coprocessor-side result modports and the CPU-side result modport.

## Interface
Parameters:
- `NUM_COP`, default 2: number of coprocessors; must be ≥1.
- `result_t`, default `logic [31:0]`: type parameter; the result payload struct (hartid, id, data, rd, we, ecswe, ecsdata, exc, exccode, dbg, err).
- `IDX_W`, default `NUM_COP>1 ? $clog2(NUM_COP) : 1`: derived width of the source index; not to be overridden.

Ports:
- `clk_i` in 1: clock, rising edge; the only clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `cop_result_valid_i` in `[NUM_COP]`: per-coprocessor result valid.
- `cop_result_ready_o` out `[NUM_COP]`: per-coprocessor result ready.
- `cop_result_i` in `[NUM_COP]` x `result_t`: per-coprocessor result payload.
- `cpu_result_valid_o` out 1: result valid towards the CPU.
- `cpu_result_ready_i` in 1: CPU result ready.
- `cpu_result_o` out `result_t`: forwarded payload.
- `cpu_result_src_o` out `IDX_W`: index of the coprocessor that produced `cpu_result_o`.

## Operation
**Buffer**
- 2-entry FIFO holding `{result_t, src}`.
- Occupancy state: EMPTY, ONE, TWO.
- Push occurs when the arbiter accepts a result. Pop occurs when `cpu_result_valid_o && cpu_result_ready_i`.

**State transitions**
- EMPTY: push → ONE; otherwise stay.
- ONE: push without pop → TWO; pop without push → EMPTY; push and pop together, or neither → stay ONE.
- TWO: pop → ONE. Push is impossible in TWO.

**Arbitration**
- `accept_en = (state != TWO)`. It is registered-state only and never depends on `cpu_result_ready_i`.
- Winner: the first `i` with `cop_result_valid_i[i]`, scanning from `rr_ptr` upward and wrapping from `NUM_COP-1` to 0.
- `cop_result_ready_o[i] = accept_en && (i == winner) && any_valid`. Ready may depend combinationally on valid. At most one ready bit is high per cycle.
- On accept: push `cop_result_i[winner]` together with src=`winner`, then set `rr_ptr <= (winner+1) mod NUM_COP`.
- With no accept, `rr_ptr` holds.
- `NUM_COP==1`: `rr_ptr` is constant 0 and src is always 0.

**Output**
- `cpu_result_valid_o = (state != EMPTY)`.
- `cpu_result_o` and `cpu_result_src_o` come from the head entry.
- Once valid, the output is held stable until it is popped.
- Results are forwarded in acceptance order. There is no reordering by id.

**Boundaries and errors**
- A requester that drops valid before it is granted is simply skipped. No payload is captured.
- Payload is sampled only in the cycle of the handshake.

**Reset**
- `rst_ni` low asynchronously clears: state → EMPTY, `rr_ptr` → 0, FIFO read/write pointers → 0.
- Resulting outputs: `cpu_result_valid_o=0`, `cpu_result_o='0`, `cpu_result_src_o=0`.
- `cop_result_ready_o` is 0 whenever no valid is asserted.
- Reset mid-transfer discards buffered results.

## Timing
- Latency: a result accepted in cycle N appears on `cpu_result_valid_o` in cycle N+1.
- Throughput: one result per cycle while `cpu_result_ready_i` stays high.
- With `cpu_result_ready_i` low: two results are buffered, then every `cop_result_ready_o` is 0 from the cycle after the second push.
- After a pop in TWO, `accept_en` is 1 in the next cycle.
- No combinational path exists from `cpu_result_ready_i` to any `cop_result_ready_o`.
- The only combinational path to `cop_result_ready_o` is from `cop_result_valid_i`.

## Structure
- The shared package `cv_xif_pkg` holds:
  - the result struct typedef used for `result_t`;
  - the helper function for `IDX_W`;
  - the occupancy-state enum `{EMPTY, ONE, TWO}`.
- Sub-module `cv_xif_rr_arbiter`: combinational round-robin winner select (inputs: valid vector and `rr_ptr`; outputs: winner index and `any_valid`). `rr_ptr` itself stays in the top level.
- The FIFO is coded inline.

## Test plan
- Reset with all `cop_result_valid_i`=1 → `cpu_result_valid_o`=0 during reset. After release: cop0 is granted first, `cpu_result_src_o`=0 in the next cycle.
- `NUM_COP`=3, all valid continuously, `cpu_result_ready_i`=1 → grants 0,1,2,0,1,2 on consecutive cycles. Output is valid every cycle from cycle 1, with src following the same sequence.
- `cpu_result_ready_i`=0, cop1 presents id=5 then id=6 → both are accepted (state TWO). `cop_result_ready_o`=0 from then on. The output holds id=5 stable for 10 cycles. When ready is raised: id=5 and id=6 pop on consecutive cycles, and cop accepts resume one cycle after the first pop.
- State ONE with simultaneous push (cop2, data=0xA5) and pop → state stays ONE. The next output is the cop2 entry, data=0xA5, src=2.
- `rr_ptr`=2 with only cop0 and cop1 valid → cop0 is granted (wrap-around). `rr_ptr` becomes 1, so cop1 wins the next cycle.
- Assert `rst_ni` low while in TWO → `cpu_result_valid_o` goes to 0 immediately (asynchronous). Buffered results are never presented.
